pipe_fwd_scoreboard: RTL and testbench
======================================

PIPE_FWD_SCOREBOARD -- requirements
Module: pipe_fwd_scoreboard

Interface
REQ-001 Parameter ADDR_W, default 5, register-address width.
REQ-002 Parameter DEPTH, default 2, number of stages after EX that can forward (legal 2..6); stage 1 = MEM, stage 2 = WB, and so on.
REQ-003 Parameter LOAD_STAGE, default 2, first stage index at which load data can be forwarded (legal 1..DEPTH).
REQ-004 Parameter MEM2MEM, default 1, enables the store-data memory-to-memory path for a load followed by a store.
REQ-005 Derived constant SEL_W = clog2(DEPTH+1), forward-select width.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 id_valid  in  1  instruction present in ID.
REQ-009 id_rs, id_rt  in  ADDR_W each  ID source registers.
REQ-010 id_use_rs, id_use_rt  in  1 each  operand actually read.
REQ-011 id_rd  in  ADDR_W  ID destination register.
REQ-012 id_regwrite, id_memread, id_memwrite  in  1 each  ID control bits.
REQ-013 flush  in  1  kill the ID instruction (taken branch).
REQ-014 stall  out  1  hold PC and IF/ID; bubble into EX.
REQ-015 fwd_a, fwd_b  out  SEL_W each  EX operand source: 0 = register file, k = stage k.
REQ-016 fwd_mem  out  1  store in MEM takes its data from the WB-stage load.
REQ-017 stall_cnt  out  32  saturating count of stall cycles.

Function
REQ-018 Tag pipeline: stages 0 (EX) .. DEPTH hold {valid, rs, rt, rd, regwrite, memread, memwrite}; each cycle stage k+1 <= stage k.
REQ-019 Stage 0 loads ID fields when id_valid & !stall & !flush; otherwise stage 0 loads a bubble (valid = 0).
REQ-020 A stage k "produces r" when valid & regwrite & rd == r & rd != 0.
REQ-021 fwd_a = smallest k in 1..DEPTH whose stage produces stage0.rs, else 0; fwd_b is the same for stage0.rt. The youngest producer wins.
REQ-022 fwd_a/fwd_b are combinational from registered state, so they are valid in the same cycle the instruction is in EX. Both are 0 when stage 0 is invalid.
REQ-023 Stall term: id_valid & !flush & an ID operand in use (rs or rt) matches a stage j in 0..DEPTH-1 that produces it with memread, and j+1 < LOAD_STAGE.
REQ-024 Stall exemption: when MEM2MEM=1, id_memwrite=1, only rt matches, and the load is in stage 0, no stall is raised.
REQ-025 fwd_mem = 1 when stage 1 is a valid memwrite, stage 2 produces stage1.rt with memread, and MEM2MEM=1.
REQ-026 A stall lasts exactly until the load reaches stage LOAD_STAGE-1. Default: one cycle per load-use pair.
REQ-027 flush overrides stall: stall = 0 and stage 0 receives a bubble.
REQ-028 stall_cnt increments by 1 each cycle stall=1 and holds at 0xFFFFFFFF.

Reset
REQ-029 While reset=1 at an edge, all stage valid bits clear and stall_cnt clears to 0.
REQ-030 After reset: stall=0, fwd_a=0, fwd_b=0, fwd_mem=0. Reset mid-stall drops the stall on the next cycle.

Structure
REQ-031 A shared package holds the stage-tag struct, the forward-select encoding constants (FWD_RF=0) and the parameter defaults.
REQ-032 One sub-module, fwd_prio_sel, performs the priority match of one operand against all stages and is instantiated twice (operands a and b).
REQ-033 All storage is in the tag pipeline and stall_cnt; no other state.

Verification
REQ-034 Back-to-back ALU: add r3 then sub r4,r3,r5 -> second instruction in EX sees fwd_a=1, fwd_b=0, stall=0.
REQ-035 Two-apart dependency: add r3, nop, and r6,r3,r3 -> fwd_a=2, fwd_b=2.
REQ-036 Double producer: add r3 at stage 2 and add r3 at stage 1 -> fwd_a=1, youngest wins.
REQ-037 Load-use: lw r2 then add r7,r2,r1 -> stall=1 for exactly one cycle, bubble in EX, then fwd_a=2; stall_cnt=1.
REQ-038 Load-store: lw r2 then sw r2,0(r9) with MEM2MEM=1 -> stall=0, fwd_mem=1 when the store is in MEM; with MEM2MEM=0 -> one stall cycle.
REQ-039 r0 and flush: add r0 then use r0 -> fwd_a=0; flush during a load-use stall -> stall=0 that cycle, bubble enters EX.

Source files
------------

// File: rtl/pipe_fwd_scoreboard_pkg.sv
// Shared types and constants for the forwarding/hazard scoreboard.
// Stage tags carry register addresses at a fixed width so one struct serves every ADDR_W.
package pipe_fwd_scoreboard_pkg;

    localparam int unsigned DEF_ADDR_W     = 5;
    localparam int unsigned DEF_DEPTH      = 2;
    localparam int unsigned DEF_LOAD_STAGE = 2;
    localparam int unsigned DEF_MEM2MEM    = 1;

    // Upper bound on ADDR_W; narrower addresses are zero-extended into the tag.
    localparam int unsigned TAG_ADDR_W = 8;

    localparam int unsigned FWD_RF = 0;

    typedef struct packed {
        logic                  valid;
        logic [TAG_ADDR_W-1:0] rs;
        logic [TAG_ADDR_W-1:0] rt;
        logic [TAG_ADDR_W-1:0] rd;
        logic                  regwrite;
        logic                  memread;
        logic                  memwrite;
    } stageTag_t;

endpackage

// File: rtl/fwd_prio_sel.sv
// Priority match of one EX operand against the producing stages 1..DEPTH.
// The youngest (lowest-numbered) producer wins; no match selects the register file.
module fwd_prio_sel
    import pipe_fwd_scoreboard_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned SEL_W = 2,
    parameter int unsigned AW    = TAG_ADDR_W
) (
    input  logic                  srcValid,
    input  logic [AW-1:0]         srcReg,
    input  logic [DEPTH-1:0]      prodMask,
    input  logic [DEPTH*AW-1:0]   prodRd,
    output logic [SEL_W-1:0]      sel
);

    always_comb begin
        sel = SEL_W'(FWD_RF);
        if (srcValid) begin
            // Scan oldest to youngest so the youngest match is the final assignment.
            for (int k = int'(DEPTH); k >= 1; k--) begin
                if (prodMask[k-1] && (prodRd[(k-1)*AW +: AW] == srcReg)) begin
                    sel = SEL_W'(k);
                end
            end
        end
    end

endmodule

// File: rtl/pipe_fwd_scoreboard.sv
// Operand-forwarding and load-use hazard scoreboard for an in-order pipeline.
// Tracks destination tags from EX through DEPTH later stages and derives stall/forward selects.
module pipe_fwd_scoreboard
    import pipe_fwd_scoreboard_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DEPTH      = DEF_DEPTH,
    parameter int unsigned LOAD_STAGE = DEF_LOAD_STAGE,
    parameter int unsigned MEM2MEM    = DEF_MEM2MEM,
    localparam int unsigned SEL_W     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rs,
    input  logic [ADDR_W-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [ADDR_W-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              id_memwrite,
    input  logic              flush,
    output logic              stall,
    output logic [SEL_W-1:0]  fwd_a,
    output logic [SEL_W-1:0]  fwd_b,
    output logic              fwd_mem,
    output logic [31:0]       stall_cnt
);

    stageTag_t stageQ [DEPTH+1];
    stageTag_t stageD [DEPTH+1];
    logic [31:0] stallCntQ;

    logic [TAG_ADDR_W-1:0] idRs, idRt, idRd;
    logic [DEPTH-1:0] prodMask;
    logic [DEPTH*TAG_ADDR_W-1:0] prodRd;
    logic hazard;

    assign idRs = TAG_ADDR_W'(id_rs);
    assign idRt = TAG_ADDR_W'(id_rt);
    assign idRd = TAG_ADDR_W'(id_rd);

    always_comb begin
        prodMask = '0;
        prodRd   = '0;
        for (int k = 1; k <= int'(DEPTH); k++) begin
            prodMask[k-1] = stageQ[k].valid && stageQ[k].regwrite && (stageQ[k].rd != '0);
            prodRd[(k-1)*TAG_ADDR_W +: TAG_ADDR_W] = stageQ[k].rd;
        end
    end

    // Load-use hazard: a load too young to forward its data produces an ID operand.
    always_comb begin
        hazard = 1'b0;
        for (int j = 0; j < int'(DEPTH); j++) begin
            if (j + 1 < int'(LOAD_STAGE)) begin
                logic loadHit, rsHit, rtHit, exempt;
                loadHit = stageQ[j].valid && stageQ[j].regwrite && stageQ[j].memread
                          && (stageQ[j].rd != '0);
                rsHit   = loadHit && id_use_rs && (stageQ[j].rd == idRs);
                rtHit   = loadHit && id_use_rt && (stageQ[j].rd == idRt);
                // Store data can be picked up later via the memory-to-memory path.
                exempt  = (MEM2MEM != 0) && id_memwrite && (j == 0) && !rsHit;
                hazard  = hazard || rsHit || (rtHit && !exempt);
            end
        end
    end

    assign stall = id_valid && !flush && hazard;

    always_comb begin
        stageD[0] = '0;
        if (id_valid && !stall && !flush) begin
            stageD[0] = '{valid: 1'b1, rs: idRs, rt: idRt, rd: idRd,
                          regwrite: id_regwrite, memread: id_memread, memwrite: id_memwrite};
        end
        for (int k = 1; k <= int'(DEPTH); k++) begin
            stageD[k] = stageQ[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k <= int'(DEPTH); k++) begin
                stageQ[k] <= '0;
            end
            stallCntQ <= '0;
        end else begin
            stageQ <= stageD;
            if (stall && (stallCntQ != 32'hFFFF_FFFF)) begin
                stallCntQ <= stallCntQ + 32'd1;
            end
        end
    end

    assign stall_cnt = stallCntQ;

    assign fwd_mem = (MEM2MEM != 0) && stageQ[1].valid && stageQ[1].memwrite
                     && stageQ[2].valid && stageQ[2].regwrite && stageQ[2].memread
                     && (stageQ[2].rd != '0) && (stageQ[2].rd == stageQ[1].rt);

    fwd_prio_sel #(
        .DEPTH (DEPTH),
        .SEL_W (SEL_W),
        .AW    (TAG_ADDR_W)
    ) u_sel_a (
        .srcValid (stageQ[0].valid),
        .srcReg   (stageQ[0].rs),
        .prodMask (prodMask),
        .prodRd   (prodRd),
        .sel      (fwd_a)
    );

    fwd_prio_sel #(
        .DEPTH (DEPTH),
        .SEL_W (SEL_W),
        .AW    (TAG_ADDR_W)
    ) u_sel_b (
        .srcValid (stageQ[0].valid),
        .srcReg   (stageQ[0].rt),
        .prodMask (prodMask),
        .prodRd   (prodRd),
        .sel      (fwd_b)
    );

endmodule

// File: tb/tb_pipe_fwd_scoreboard.sv
// Directed bench for pipe_fwd_scoreboard: default instance plus a MEM2MEM=0 instance on shared inputs.
module tb_pipe_fwd_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       id_use_rs, id_use_rt;
    logic       id_regwrite, id_memread, id_memwrite;
    logic       flush;

    logic        stall, fwd_mem;
    logic [1:0]  fwd_a, fwd_b;
    logic [31:0] stall_cnt;
    logic        stallN, fwdMemN;
    logic [1:0]  fwdAN, fwdBN;
    logic [31:0] stallCntN;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_fwd_scoreboard u_dut (
        .clk         (clk),
        .reset       (reset),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_use_rs   (id_use_rs),
        .id_use_rt   (id_use_rt),
        .id_rd       (id_rd),
        .id_regwrite (id_regwrite),
        .id_memread  (id_memread),
        .id_memwrite (id_memwrite),
        .flush       (flush),
        .stall       (stall),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b),
        .fwd_mem     (fwd_mem),
        .stall_cnt   (stall_cnt)
    );

    pipe_fwd_scoreboard #(
        .MEM2MEM (0)
    ) u_dut_nm (
        .clk         (clk),
        .reset       (reset),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_use_rs   (id_use_rs),
        .id_use_rt   (id_use_rt),
        .id_rd       (id_rd),
        .id_regwrite (id_regwrite),
        .id_memread  (id_memread),
        .id_memwrite (id_memwrite),
        .flush       (flush),
        .stall       (stallN),
        .fwd_a       (fwdAN),
        .fwd_b       (fwdBN),
        .fwd_mem     (fwdMemN),
        .stall_cnt   (stallCntN)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic setId(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic [4:0] rd,
                         input logic rw, input logic mr, input logic mw, input logic fl);
        id_valid    = v;
        id_rs       = rs;
        id_rt       = rt;
        id_use_rs   = urs;
        id_use_rt   = urt;
        id_rd       = rd;
        id_regwrite = rw;
        id_memread  = mr;
        id_memwrite = mw;
        flush       = fl;
        #1;
    endtask

    task automatic idle();
        setId(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        idle();
        repeat (3) tick();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        repeat (2) tick();
        reset = 1'b0;
        #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_fwd_a", 32'(fwd_a), 32'd0);
        chk("rst_fwd_b", 32'(fwd_b), 32'd0);
        chk("rst_fwd_mem", 32'(fwd_mem), 32'd0);
        chk("rst_cnt", stall_cnt, 32'd0);

        // add r3,r1,r2 ; sub r4,r3,r5
        setId(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0, 0);
        tick();
        setId(1, 5'd3, 5'd5, 1, 1, 5'd4, 1, 0, 0, 0);
        chk("alu_b2b_stall", 32'(stall), 32'd0);
        tick();
        chk("alu_b2b_fwd_a", 32'(fwd_a), 32'd1);
        chk("alu_b2b_fwd_b", 32'(fwd_b), 32'd0);

        // add r3 ; nop ; and r6,r3,r3
        setId(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0, 0);
        tick();
        idle();
        tick();
        setId(1, 5'd3, 5'd3, 1, 1, 5'd6, 1, 0, 0, 0);
        tick();
        chk("two_apart_fwd_a", 32'(fwd_a), 32'd2);
        chk("two_apart_fwd_b", 32'(fwd_b), 32'd2);

        // add r3 ; add r3 ; use r3,r1
        setId(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0, 0);
        tick();
        setId(1, 5'd4, 5'd5, 1, 1, 5'd3, 1, 0, 0, 0);
        tick();
        setId(1, 5'd3, 5'd1, 1, 1, 5'd8, 1, 0, 0, 0);
        tick();
        chk("dbl_prod_fwd_a", 32'(fwd_a), 32'd1);
        chk("dbl_prod_fwd_b", 32'(fwd_b), 32'd0);

        // lw r2,0(r1) ; add r7,r2,r1
        drain();
        setId(1, 5'd1, 5'd0, 1, 0, 5'd2, 1, 1, 0, 0);
        tick();
        setId(1, 5'd2, 5'd1, 1, 1, 5'd7, 1, 0, 0, 0);
        chk("lu_stall", 32'(stall), 32'd1);
        tick();
        chk("lu_bubble_fwd_a", 32'(fwd_a), 32'd0);
        chk("lu_stall_done", 32'(stall), 32'd0);
        tick();
        chk("lu_fwd_a", 32'(fwd_a), 32'd2);
        chk("lu_fwd_b", 32'(fwd_b), 32'd0);
        chk("lu_cnt", stall_cnt, 32'd1);

        // lw r2,0(r1) ; sw r2,0(r9)
        drain();
        setId(1, 5'd1, 5'd0, 1, 0, 5'd2, 1, 1, 0, 0);
        tick();
        setId(1, 5'd9, 5'd2, 1, 1, 5'd0, 0, 0, 1, 0);
        chk("ls_m2m_stall", 32'(stall), 32'd0);
        chk("ls_nom2m_stall", 32'(stallN), 32'd1);
        tick();
        chk("ls_ex_fwd_a", 32'(fwd_a), 32'd0);
        chk("ls_ex_fwd_b", 32'(fwd_b), 32'd1);
        idle();
        tick();
        chk("ls_fwd_mem", 32'(fwd_mem), 32'd1);
        chk("ls_nom2m_fwd_mem", 32'(fwdMemN), 32'd0);
        chk("ls_nom2m_cnt", stallCntN, 32'd2);

        // add r0 ; use r0
        drain();
        setId(1, 5'd1, 5'd2, 1, 1, 5'd0, 1, 0, 0, 0);
        tick();
        setId(1, 5'd0, 5'd0, 1, 1, 5'd5, 1, 0, 0, 0);
        tick();
        chk("r0_fwd_a", 32'(fwd_a), 32'd0);
        chk("r0_fwd_b", 32'(fwd_b), 32'd0);

        // flush during a load-use stall
        drain();
        setId(1, 5'd1, 5'd0, 1, 0, 5'd2, 1, 1, 0, 0);
        tick();
        setId(1, 5'd2, 5'd1, 1, 1, 5'd7, 1, 0, 0, 1);
        chk("flush_stall", 32'(stall), 32'd0);
        tick();
        chk("flush_bubble_fwd_a", 32'(fwd_a), 32'd0);
        chk("flush_cnt", stall_cnt, 32'd1);

        // reset mid-stall
        drain();
        setId(1, 5'd1, 5'd0, 1, 0, 5'd2, 1, 1, 0, 0);
        tick();
        setId(1, 5'd2, 5'd1, 1, 1, 5'd7, 1, 0, 0, 0);
        chk("rst_mid_stall_pre", 32'(stall), 32'd1);
        reset = 1'b1;
        tick();
        chk("rst_mid_stall_post", 32'(stall), 32'd0);
        chk("rst_mid_cnt", stall_cnt, 32'd0);
        reset = 1'b0;
        idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
